// File: rtl/period_sched_pkg.sv
// period_sched_pkg: FSM state encoding, default parameters and round-robin pick helper
package period_sched_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int CNT_W_DEF   = 24;
    localparam int TIMEOUT_DEF = 2**20 - 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_EDGE,
        COUNT,
        RESULT
    } state_t;

    // Returns {found, index} of the first set bit of r at or after p, wrapping at n
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p, input int n);
        logic [3:0] res;
        int k;
        res = '0;
        for (int i = n - 1; i >= 0; i--) begin
            k = (int'(p) + i) % n;
            if (r[3'(k)]) res = {1'b1, 3'(k)};
        end
        return res;
    endfunction

endpackage

// File: rtl/period_sched_edge_sync.sv
// edge_sync: 2-FF synchronizer for one monitored clock plus a rising-edge pulse
module edge_sync (
    input  logic clk,
    input  logic RSTN,
    input  logic clr,
    input  logic d,
    output logic pulse
);

    logic [2:0] sh;

    // sh[1:0] resynchronize d into clk, sh[2] holds the previous synchronized level
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) sh <= '0;
        else if (clr) sh <= '0;
        else sh <= {sh[1:0], d};
    end

    assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/period_sched.sv
// period_sched: round-robin scheduler measuring the period of N_CH asynchronous clocks.
// Optional macro PERIOD_SCHED_AVG_EN: average over 4 consecutive periods instead of one.
module period_sched
    import period_sched_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    RSTN,
    input  logic                    PWRDWN,
    input  logic [N_CH-1:0]         meas_clk,
    input  logic [N_CH-1:0]         req,
    output logic [N_CH-1:0]         grant,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(N_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]        res_period,
    output logic                    res_timeout
);

    localparam int IW = $clog2(N_CH);
`ifdef PERIOD_SCHED_AVG_EN
    localparam int NPER = 4;
    localparam int SH   = 2;
`else
    localparam int NPER = 1;
    localparam int SH   = 0;
`endif

    logic [N_CH-1:0]  edge_p;
    state_t           state, state_nxt;
    logic [N_CH-1:0]  grant_nxt;
    logic [IW-1:0]    ch_nxt, ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, per_nxt, total;
    logic [1:0]       ecnt, ecnt_nxt;
    logic             tmo_nxt, hit, at_tmo;
    logic [3:0]       pick;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        edge_sync u_sync (
            .clk  (clk),
            .RSTN (RSTN),
            .clr  (PWRDWN),
            .d    (meas_clk[g]),
            .pulse(edge_p[g])
        );
    end

    assign pick      = rr_pick(8'(req), 3'(ptr), N_CH);
    assign hit       = edge_p[res_ch];
    assign at_tmo    = cnt == CNT_W'(TIMEOUT);
    assign total     = cnt + CNT_W'(1);
    assign busy      = state != IDLE;
    assign res_valid = state == RESULT;

    // Next-state, arbitration and measurement datapath; PWRDWN forces the reset values
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ch_nxt    = res_ch;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        ecnt_nxt  = ecnt;
        per_nxt   = res_period;
        tmo_nxt   = res_timeout;
        case (state)
            IDLE: if (|req) state_nxt = ARB;
            ARB: begin
                if (pick[3]) begin
                    state_nxt = WAIT_EDGE;
                    grant_nxt = N_CH'(1) << pick[2:0];
                    ch_nxt    = IW'(pick[2:0]);
                    ptr_nxt   = (pick[2:0] == 3'(N_CH - 1)) ? '0 : IW'(pick[2:0] + 3'd1);
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_EDGE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (at_tmo) begin
                    state_nxt = RESULT;
                    per_nxt   = '0;
                    tmo_nxt   = 1'b1;
                end else if (hit) begin
                    state_nxt = COUNT;
                    cnt_nxt   = '0;
                    ecnt_nxt  = '0;
                end
            end
            COUNT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (at_tmo) begin
                    state_nxt = RESULT;
                    per_nxt   = '0;
                    tmo_nxt   = 1'b1;
                end else if (hit && ecnt == 2'(NPER - 1)) begin
                    state_nxt = RESULT;
                    per_nxt   = total >> SH;
                    tmo_nxt   = 1'b0;
                end else if (hit) begin
                    ecnt_nxt = ecnt + 2'd1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_nxt = (|req) ? ARB : IDLE;
                    grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (PWRDWN) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ch_nxt    = '0;
            ptr_nxt   = '0;
            cnt_nxt   = '0;
            ecnt_nxt  = '0;
            per_nxt   = '0;
            tmo_nxt   = 1'b0;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            grant       <= '0;
            res_ch      <= '0;
            ptr         <= '0;
            cnt         <= '0;
            ecnt        <= '0;
            res_period  <= '0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            res_ch      <= ch_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            ecnt        <= ecnt_nxt;
            res_period  <= per_nxt;
            res_timeout <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_period_sched.sv
// tb_period_sched: directed and randomized checks of period_sched against a behavioural model
module tb_period_sched;

    localparam int N  = 4;
    localparam int CW = 24;
    localparam int TO = 300;

    logic          clk = 1'b0;
    logic          RSTN = 1'b0;
    logic          PWRDWN = 1'b0;
    logic [N-1:0]  meas_clk = '0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  grant;
    logic          busy, res_valid, res_timeout;
    logic          res_ready = 1'b1;
    logic [1:0]    res_ch;
    logic [CW-1:0] res_period;

    int checks = 0;
    int errors = 0;
    int pt[N][4];
    int ph[N];
    int pi[N];
    bit en[N];
    int rr_ptr = 0;

    always #5 clk = ~clk;

    period_sched #(.N_CH(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .RSTN       (RSTN),
        .PWRDWN     (PWRDWN),
        .meas_clk   (meas_clk),
        .req        (req),
        .grant      (grant),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ch     (res_ch),
        .res_period (res_period),
        .res_timeout(res_timeout)
    );

    // Monitored clocks: each channel cycles through its 4-entry period table, rising when ph wraps
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            if (!en[c]) begin
                ph[c] = 0;
                pi[c] = 0;
                meas_clk[c] = 1'b0;
            end else begin
                ph[c]++;
                if (ph[c] >= pt[c][pi[c]]) begin
                    ph[c] = 0;
                    pi[c] = (pi[c] + 1) % 4;
                end
                meas_clk[c] = ph[c] < pt[c][pi[c]] / 2;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_per(input int c, input int p);
        for (int k = 0; k < 4; k++) pt[c][k] = p;
        en[c] = 1'b1;
    endtask

    function automatic int rr_next(input int mask);
        for (int i = 0; i < N; i++)
            if (mask[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        return -1;
    endfunction

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("grant_wait", 64'(grant != '0), 64'd1);
    endtask

    task automatic wait_res(input int ech, input int eper, input bit etmo);
        int n = 0;
        while (!res_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("res_wait", 64'(res_valid), 64'd1);
        if (res_valid) begin
            chk("res_ch", 64'(res_ch), 64'(ech));
            chk("res_period", 64'(res_period), 64'(eper));
            chk("res_timeout", 64'(res_timeout), 64'(etmo));
            chk("res_grant", 64'(grant), 64'd1 << ech);
        end
        rr_ptr = (ech + 1) % N;
        if (res_ready) @(negedge clk);
    endtask

    initial begin
        int e, mask, n;
        logic [CW-1:0] held;
        for (int c = 0; c < N; c++) en[c] = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_ch", 64'(res_ch), 64'd0);
        chk("rst_period", 64'(res_period), 64'd0);
        chk("rst_timeout", 64'(res_timeout), 64'd0);
        RSTN = 1'b1;
        @(negedge clk);

        // all channels requesting: grants rotate 0,1,2,3,0
        for (int c = 0; c < N; c++) set_per(c, $urandom_range(4, 30));
        repeat (100) @(negedge clk);
        req = 4'hF;
        for (int k = 0; k < 5; k++) wait_res(k % 4, pt[k % 4][0], 1'b0);
        req = '0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // single channel, period 10
        set_per(0, 10);
        repeat (60) @(negedge clk);
        req = 4'b0001;
        wait_res(0, 10, 1'b0);
        req = '0;

        // randomized request masks and periods
        repeat (12) begin
            for (int c = 0; c < N; c++) set_per(c, $urandom_range(4, 30));
            repeat (64) @(negedge clk);
            mask = $urandom_range(1, 15);
            req = 4'(mask);
            e = rr_next(mask);
            wait_res(e, pt[e][0], 1'b0);
            req = '0;
        end

        // channel 1 never toggles: timeout
        en[1] = 1'b0;
        repeat (4) @(negedge clk);
        req = 4'b0010;
        wait_grant();
        n = 0;
        while (!res_valid && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 64'(n >= TO - 1 && n <= TO + 2), 64'd1);
        wait_res(1, 0, 1'b1);
        req = '0;
        set_per(1, 12);

        // back-pressure while req is withdrawn mid-measurement
        set_per(2, 13);
        repeat (60) @(negedge clk);
        res_ready = 1'b0;
        req = 4'b0100;
        wait_grant();
        req = '0;
        wait_res(2, 13, 1'b0);
        held = res_period;
        repeat (20) begin
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_period", 64'(res_period), 64'(held));
            chk("hold_ch", 64'(res_ch), 64'd2);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("after_xfer_valid", 64'(res_valid), 64'd0);
        chk("after_xfer_busy", 64'(busy), 64'd0);

        // power-down during COUNT
        en[3] = 1'b0;
        for (int k = 0; k < 4; k++) pt[3][k] = 40;
        repeat (4) @(negedge clk);
        req = 4'b1000;
        wait_grant();
        en[3] = 1'b1;
        repeat (20) @(negedge clk);
        chk("count_busy", 64'(busy), 64'd1);
        req = '0;
        PWRDWN = 1'b1;
        @(negedge clk);
        chk("pd_grant", 64'(grant), 64'd0);
        chk("pd_busy", 64'(busy), 64'd0);
        chk("pd_valid", 64'(res_valid), 64'd0);
        PWRDWN = 1'b0;
        rr_ptr = 0;
        @(negedge clk);
        chk("pd_stay_idle", 64'(busy), 64'd0);

        // power-down in RESULT discards the result
        set_per(0, 8);
        repeat (40) @(negedge clk);
        res_ready = 1'b0;
        req = 4'b0001;
        wait_res(0, 8, 1'b0);
        req = '0;
        PWRDWN = 1'b1;
        @(negedge clk);
        chk("pdr_valid", 64'(res_valid), 64'd0);
        chk("pdr_period", 64'(res_period), 64'd0);
        PWRDWN = 1'b0;
        res_ready = 1'b1;
        rr_ptr = 0;
        repeat (3) @(negedge clk);
        chk("pdr_discard", 64'(res_valid), 64'd0);

        // round-robin pointer restarts at channel 0
        req = 4'b1001;
        e = rr_next(9);
        wait_res(e, pt[e][0], 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // asynchronous reset mid-measurement
        req = 4'b0001;
        wait_grant();
        req = '0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        RSTN = 1'b1;
        rr_ptr = 0;
        @(negedge clk);

`ifdef PERIOD_SCHED_AVG_EN
        // averaged periods 10,11,10,11 -> 42>>2 = 10
        pt[2][0] = 10;
        pt[2][1] = 11;
        pt[2][2] = 10;
        pt[2][3] = 11;
        repeat (100) @(negedge clk);
        req = 4'b0100;
        wait_res(2, 10, 1'b0);
        req = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_sched.md
PERIOD_SCHED -- requirements
Module: period_sched

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of monitored clock channels (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 24, meaning the width of the period counter in clk cycles.
REQ-003 The block SHALL have parameter TIMEOUT, default 2**20-1, meaning the maximum clk cycles to wait for an edge before aborting.
REQ-004 Port clk  input  1  is the single system clock; all logic is rising-edge clocked.
REQ-005 Port RSTN  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-006 Port PWRDWN  input  1  is a synchronous active-high power-down.
REQ-007 Port meas_clk  input  N_CH  carries the monitored clocks; they are asynchronous to clk.
REQ-008 Port req  input  N_CH  carries per-channel measurement requests, level-sensitive.
REQ-009 Port grant  output  N_CH  is a one-hot indication of the channel currently owning the engine.
REQ-010 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-011 Port res_valid / res_ready  output / input  1 / 1  form the result handshake.
REQ-012 Port res_ch  output  $clog2(N_CH)  is the channel index of the result.
REQ-013 Port res_period  output  CNT_W  is the measured period in clk cycles.
REQ-014 Port res_timeout  output  1  indicates the measurement aborted on timeout.

Function
REQ-015 Each meas_clk bit SHALL pass a 2-FF synchronizer plus an edge register; a rising edge is detected 3 clk after it occurs.
REQ-016 The FSM SHALL have states IDLE, ARB, WAIT_EDGE, COUNT and RESULT.
- IDLE->ARB when any req is high.
- ARB->WAIT_EDGE after one cycle, with grant set.
- WAIT_EDGE->COUNT on the first detected edge of the granted channel.
- COUNT->RESULT on the closing edge, or on timeout.
- RESULT->ARB if req!=0 when the transfer occurs, else RESULT->IDLE.
REQ-017 ARB SHALL grant round-robin, starting from the channel after the last granted one; after reset the search starts at channel 0.
REQ-018 The counter SHALL clear on entry to WAIT_EDGE and on the opening edge, and increment every cycle in WAIT_EDGE and COUNT; edges N clk apart SHALL yield res_period=N.
REQ-019 If the counter reaches TIMEOUT in WAIT_EDGE or COUNT, the FSM SHALL go to RESULT with res_timeout=1 and res_period=0.
REQ-020 res_valid SHALL be high only in RESULT; its payload SHALL be stable until res_valid&&res_ready, and the FSM leaves RESULT the cycle after the transfer.
REQ-021 A deassertion of req for the granted channel SHALL NOT abort a measurement in progress.
REQ-022 grant SHALL remain constant from ARB exit until the RESULT transfer, and SHALL be 0 in IDLE.
REQ-023 meas_clk faster than clk/4 SHALL yield a result that is not guaranteed; no error flag is required.

Reset
REQ-024 While RSTN=0, state=IDLE, and grant, busy, res_valid, res_ch, res_period, res_timeout, the counter, the synchronizers and the RR pointer SHALL all be 0.
REQ-025 PWRDWN=1 SHALL apply the same values synchronously, overriding any state including RESULT; the pending result SHALL be discarded.

Configuration
REQ-026 With macro PERIOD_SCHED_AVG_EN defined, COUNT SHALL span 4 consecutive periods and res_period SHALL be the total >>2 (truncated); without it, COUNT SHALL span one period.

Structure
REQ-027 Package period_sched_pkg SHALL hold the FSM state enum and the default constants for N_CH, CNT_W and TIMEOUT.
REQ-028 Sub-module edge_sync (2-FF synchronizer plus rising-edge pulse) SHALL be instantiated once per channel.

Verification
REQ-029 req=4'b0001, meas_clk[0] period 10 clk, res_ready=1 -> res_valid with res_ch=0, res_period=10, res_timeout=0.
REQ-030 req=4'b1111 held high, res_ready=1 -> grants in order ch0, ch1, ch2, ch3, ch0.
REQ-031 req=4'b0010, meas_clk[1] constant low -> after TIMEOUT cycles, res_timeout=1 and res_period=0.
REQ-032 res_ready=0 for 20 cycles during RESULT -> payload unchanged; the FSM leaves RESULT only after res_ready=1.
REQ-033 PWRDWN pulsed during COUNT -> next cycle IDLE, grant=0, res_valid=0; RSTN low in any state clears immediately.
REQ-034 With PERIOD_SCHED_AVG_EN defined, periods 10,11,10,11 clk -> res_period=10.
